// File: rtl/gpu_video_pkg.sv
// ---------------------------------------------------------------------------
// gpu_video_pkg
//   Shared definitions for the VGA output stage:
//     PIPE_STAGES  - depth of the dither/timing pipeline in pixel ticks
//     BAYER4       - 4x4 ordered-dither threshold matrix, row-major {y,x}
//     timing_t     - video timing bundle carried alongside each pixel
//     bayer_lookup - threshold for a column/row pair (2 LSBs each)
// ---------------------------------------------------------------------------
package gpu_video_pkg;

  localparam int PIPE_STAGES = 3;

  // Row-major: index = {y[1:0], x[1:0]}.
  localparam logic [3:0] BAYER4 [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } timing_t;

  function automatic logic [3:0] bayer_lookup(input logic [1:0] x2,
                                              input logic [1:0] y2);
    return BAYER4[{y2, x2}];
  endfunction

endpackage

// File: rtl/vga_dither_out_if.sv
// ---------------------------------------------------------------------------
// vga_dither_out_if
//   Bundle between the palette mixer, the dither output stage and the pins.
//   Parameters mirror the DAC widths of the output stage.
//   Mixer side  (master drives): pc_ena_in, pixel_in_r/g/b, hde_in, vde_in,
//                                hs_in, vs_in
//   Output side (slave drives):  pc_ena_out, vga_r/g/b, vga_hs, vga_vs,
//                                vga_de, frame_count
// ---------------------------------------------------------------------------
interface vga_dither_out_if #(
  parameter int OUT_R_BITS = 4,
  parameter int OUT_G_BITS = 4,
  parameter int OUT_B_BITS = 4
);

  logic [3:0]            pc_ena_in;
  logic [7:0]            pixel_in_r;
  logic [7:0]            pixel_in_g;
  logic [7:0]            pixel_in_b;
  logic                  hde_in;
  logic                  vde_in;
  logic                  hs_in;
  logic                  vs_in;

  logic [3:0]            pc_ena_out;
  logic [OUT_R_BITS-1:0] vga_r;
  logic [OUT_G_BITS-1:0] vga_g;
  logic [OUT_B_BITS-1:0] vga_b;
  logic                  vga_hs;
  logic                  vga_vs;
  logic                  vga_de;
  logic [7:0]            frame_count;

  modport master (
    output pc_ena_in, pixel_in_r, pixel_in_g, pixel_in_b,
           hde_in, vde_in, hs_in, vs_in,
    input  pc_ena_out, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
           frame_count
  );

  modport slave (
    input  pc_ena_in, pixel_in_r, pixel_in_g, pixel_in_b,
           hde_in, vde_in, hs_in, vs_in,
    output pc_ena_out, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de,
           frame_count
  );

endinterface

// File: rtl/dither_channel.sv
// ---------------------------------------------------------------------------
// dither_channel
//   One colour channel of the ordered dither: S2 adds the scaled threshold
//   and saturates, S3 truncates to the DAC width and blanks.
//   Ports:
//     clk, rst   pixel clock, asynchronous active-high reset
//     tick       pixel tick; all state holds when low
//     pixel      8-bit S1 channel value
//     thresh     4-bit S1 Bayer threshold
//     de         display enable aligned with the S2 register (blanks S3)
//     level_out  OUT_BITS-wide DAC code (S3 register)
// ---------------------------------------------------------------------------
module dither_channel #(
  parameter int OUT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [7:0]          pixel,
  input  logic [3:0]          thresh,
  input  logic                de,
  output logic [OUT_BITS-1:0] level_out
);

  // Number of LSBs dropped on the way to the DAC.
  localparam int D = 8 - OUT_BITS;

  logic [7:0]          offset;
  logic [8:0]          sum;
  logic [OUT_BITS-1:0] level;
  logic [OUT_BITS-1:0] level_s2;
  logic                unused_bits;

  // The threshold is scaled so that its 16 steps span exactly one output LSB.
  generate
    if (D == 0) begin : g_pass
      assign offset      = 8'd0;
      assign unused_bits = ^thresh;
    end else if (D <= 4) begin : g_down
      assign offset      = {4'd0, thresh} >> (4 - D);
      assign unused_bits = ^sum[D-1:0];
    end else begin : g_up
      assign offset      = {4'd0, thresh} << (D - 4);
      assign unused_bits = ^sum[D-1:0];
    end
  endgenerate

  // Ninth bit catches the carry so bright pixels clamp instead of wrapping.
  assign sum   = {1'b0, pixel} + {1'b0, offset};
  assign level = sum[8] ? '1 : sum[7:D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_s2  <= '0;
      level_out <= '0;
    end else if (tick) begin
      level_s2  <= level;
      level_out <= de ? level_s2 : '0;
    end
  end

endmodule

// File: rtl/vga_dither_out.sv
// ---------------------------------------------------------------------------
// vga_dither_out
//   VGA output stage behind the palette mixer. Reduces the 24-bit RGB stream
//   to the DAC widths with 4x4 ordered dithering, blanks outside the active
//   area and drives the pins. State advances only on pixel ticks
//   (pc_ena_in == 0); latency is PIPE_STAGES ticks for colour and timing.
//   Optional feature: define VGA_DITHER_TEMPORAL_EN to rotate the dither
//   columns by frame_count[1:0] every frame.
//   Ports:
//     clk   pixel-domain clock
//     rst   asynchronous active-high reset
//     bus   vga_dither_out_if.slave: mixer inputs, VGA pins, pc_ena_out,
//           frame_count
//   Parameters: OUT_R_BITS/OUT_G_BITS/OUT_B_BITS (1..8), SYNC_INVERT.
// ---------------------------------------------------------------------------
module vga_dither_out
  import gpu_video_pkg::*;
#(
  parameter int OUT_R_BITS  = 4,
  parameter int OUT_G_BITS  = 4,
  parameter int OUT_B_BITS  = 4,
  parameter bit SYNC_INVERT = 1'b0
) (
  input logic            clk,
  input logic            rst,
  vga_dither_out_if.slave bus
);

  logic       tick;
  logic       de_in;
  logic [9:0] x_cnt;
  logic [9:0] y_cnt;
  logic       prev_hde;
  logic       prev_vde;
  logic [7:0] frame_cnt;
  logic [1:0] col;
  logic       unused_cnt_bits;

  assign tick  = (bus.pc_ena_in == 4'd0);
  assign de_in = bus.hde_in & bus.vde_in;

  // -------------------------------------------------------------------------
  // Screen position and frame counters
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      prev_hde  <= 1'b0;
      prev_vde  <= 1'b0;
      frame_cnt <= '0;
    end else if (tick) begin
      prev_hde <= bus.hde_in;
      prev_vde <= bus.vde_in;

      if (!bus.hde_in)
        x_cnt <= '0;
      else if (de_in)
        x_cnt <= x_cnt + 10'd1;

      // A vde fall also clears y, so a coincident hde fall never counts.
      if (!bus.vde_in)
        y_cnt <= '0;
      else if (prev_hde && !bus.hde_in)
        y_cnt <= y_cnt + 10'd1;

      if (prev_vde && !bus.vde_in)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign bus.frame_count = frame_cnt;

  // Only the two LSBs address the Bayer matrix.
  assign unused_cnt_bits = ^{x_cnt[9:2], y_cnt[9:2]};

  // NOTE: combinational blocks assign every output first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    col = x_cnt[1:0];
`ifdef VGA_DITHER_TEMPORAL_EN
    col = x_cnt[1:0] + frame_cnt[1:0];
`endif
  end

  // -------------------------------------------------------------------------
  // S1: register pixel and timing, look up the threshold for this position
  // -------------------------------------------------------------------------
  logic [7:0] r_s1;
  logic [7:0] g_s1;
  logic [7:0] b_s1;
  logic [3:0] thresh_s1;

  // Element 0 is S1; the last element is the timing aligned with S2.
  timing_t [PIPE_STAGES-2:0] tim_pipe;
  timing_t                   tim_new;
  timing_t                   tim_s2;

  assign tim_new = '{de: de_in, hs: bus.hs_in, vs: bus.vs_in};
  assign tim_s2  = tim_pipe[PIPE_STAGES-2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1      <= '0;
      g_s1      <= '0;
      b_s1      <= '0;
      thresh_s1 <= '0;
      // NOTE: this pipe is a handful of flops, so it is reset like any other
      // register; large storage arrays would be left unreset instead.
      tim_pipe  <= '0;
    end else if (tick) begin
      r_s1      <= bus.pixel_in_r;
      g_s1      <= bus.pixel_in_g;
      b_s1      <= bus.pixel_in_b;
      thresh_s1 <= bayer_lookup(col, y_cnt[1:0]);
      tim_pipe[0] <= tim_new;
      for (int i = 1; i < PIPE_STAGES - 1; i++)
        tim_pipe[i] <= tim_pipe[i-1];
    end
  end

  // -------------------------------------------------------------------------
  // S2/S3: per-channel dither; blanking uses the de that lands in vga_de on
  // the same tick, so colour and de stay aligned.
  // -------------------------------------------------------------------------
  dither_channel #(.OUT_BITS(OUT_R_BITS)) u_red (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .pixel     (r_s1),
    .thresh    (thresh_s1),
    .de        (tim_s2.de),
    .level_out (bus.vga_r)
  );

  dither_channel #(.OUT_BITS(OUT_G_BITS)) u_green (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .pixel     (g_s1),
    .thresh    (thresh_s1),
    .de        (tim_s2.de),
    .level_out (bus.vga_g)
  );

  dither_channel #(.OUT_BITS(OUT_B_BITS)) u_blue (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .pixel     (b_s1),
    .thresh    (thresh_s1),
    .de        (tim_s2.de),
    .level_out (bus.vga_b)
  );

  // S3 timing registers; sync polarity is applied here so the pins idle at
  // the inactive level straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.vga_de <= 1'b0;
      bus.vga_hs <= SYNC_INVERT;
      bus.vga_vs <= SYNC_INVERT;
    end else if (tick) begin
      bus.vga_de <= tim_s2.de;
      bus.vga_hs <= tim_s2.hs ^ SYNC_INVERT;
      bus.vga_vs <= tim_s2.vs ^ SYNC_INVERT;
    end
  end

  // Phase is forwarded every clock so downstream logic keeps the same
  // tick alignment one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.pc_ena_out <= 4'd0;
    else
      bus.pc_ena_out <= bus.pc_ena_in;
  end

endmodule

// File: tb/tb_vga_dither_out.sv
// ---------------------------------------------------------------------------
// tb_vga_dither_out
//   Directed bench for vga_dither_out. Two instances share one stimulus:
//     dut_a: 4/4/4 bits, SYNC_INVERT = 0
//     dut_b: R=6 (2 LSBs dropped), G=8 (pass-through), B=1 (7 dropped),
//            SYNC_INVERT = 1
//   Expected values are worked out by hand from the Bayer matrix.
//   Honours VGA_DITHER_TEMPORAL_EN for the frame-shift check.
// ---------------------------------------------------------------------------
module tb_vga_dither_out;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pc;
  logic [7:0] r_in, g_in, b_in;
  logic       hde, vde, hs, vs;
  int         phase;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  vga_dither_out_if #(.OUT_R_BITS(4), .OUT_G_BITS(4), .OUT_B_BITS(4)) bus_a ();
  vga_dither_out_if #(.OUT_R_BITS(6), .OUT_G_BITS(8), .OUT_B_BITS(1)) bus_b ();

  assign bus_a.pc_ena_in  = pc;
  assign bus_a.pixel_in_r = r_in;
  assign bus_a.pixel_in_g = g_in;
  assign bus_a.pixel_in_b = b_in;
  assign bus_a.hde_in     = hde;
  assign bus_a.vde_in     = vde;
  assign bus_a.hs_in      = hs;
  assign bus_a.vs_in      = vs;

  assign bus_b.pc_ena_in  = pc;
  assign bus_b.pixel_in_r = r_in;
  assign bus_b.pixel_in_g = g_in;
  assign bus_b.pixel_in_b = b_in;
  assign bus_b.hde_in     = hde;
  assign bus_b.vde_in     = vde;
  assign bus_b.hs_in      = hs;
  assign bus_b.vs_in      = vs;

  vga_dither_out #(
    .OUT_R_BITS(4), .OUT_G_BITS(4), .OUT_B_BITS(4), .SYNC_INVERT(1'b0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  vga_dither_out #(
    .OUT_R_BITS(6), .OUT_G_BITS(8), .OUT_B_BITS(1), .SYNC_INVERT(1'b1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock at the current phase; returns on the following falling edge.
  task automatic step();
    pc = 4'(phase);
    @(negedge clk);
    phase = (phase + 1) % 4;
  endtask

  // One pixel: inputs presented for a full 4-clock pixel, tick first.
  task automatic pix(input logic h, input logic v, input logic hsy,
                     input logic vsy, input logic [7:0] rr,
                     input logic [7:0] gg, input logic [7:0] bb);
    hde  = h;
    vde  = v;
    hs   = hsy;
    vs   = vsy;
    r_in = rr;
    g_in = gg;
    b_in = bb;
    repeat (4) step();
  endtask

  int         lat;
  logic [3:0] r_rise;

  initial begin
    phase = 0;
    rst   = 1'b1;
    pc    = 4'd0;
    {hde, vde, hs, vs} = 4'b0000;
    {r_in, g_in, b_in} = '0;

    // Reset state
    repeat (8) step();
    check("rst_a_r",   bus_a.vga_r, 4'h0);
    check("rst_a_de",  bus_a.vga_de, 1'b0);
    check("rst_a_hs",  bus_a.vga_hs, 1'b0);
    check("rst_b_hs",  bus_b.vga_hs, 1'b1);
    check("rst_b_vs",  bus_b.vga_vs, 1'b1);
    check("rst_a_fc",  bus_a.frame_count, 8'd0);
    check("rst_a_pco", bus_a.pc_ena_out, 4'd0);
    rst = 1'b0;

    // Vertical blank, then line y=0 at frame 0
    pix(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    pix(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    pix(1, 1, 0, 0, 8'h80, 8'h80, 8'h80);   // x0 t=0
    pix(1, 1, 0, 0, 8'h88, 8'h88, 8'h88);   // x1 t=8
    pix(1, 1, 0, 0, 8'hFF, 8'hFF, 8'hFF);   // x2 t=2
    check("t0_a_r",  bus_a.vga_r, 4'h8);
    check("t0_a_g",  bus_a.vga_g, 4'h8);
    check("t0_a_b",  bus_a.vga_b, 4'h8);
    check("t0_a_de", bus_a.vga_de, 1'b1);
    check("t0_b_r",  bus_b.vga_r, 6'h20);
    check("t0_b_g",  bus_b.vga_g, 8'h80);
    check("t0_b_b",  bus_b.vga_b, 1'b1);

    pix(0, 1, 1, 0, 8'hFF, 8'hFF, 8'hFF);   // blank with hs and bright RGB
    check("t8_a_r",  bus_a.vga_r, 4'h9);
    check("t8_b_r",  bus_b.vga_r, 6'h22);
    check("t8_b_g",  bus_b.vga_g, 8'h88);
    check("t8_b_b",  bus_b.vga_b, 1'b1);

    pix(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    check("t2sat_a_r", bus_a.vga_r, 4'hF);
    check("t2sat_b_r", bus_b.vga_r, 6'h3F);
    check("t2sat_b_g", bus_b.vga_g, 8'hFF);
    check("hs_idle_a", bus_a.vga_hs, 1'b0);
    check("hs_idle_b", bus_b.vga_hs, 1'b1);

    pix(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    check("blank_a_r",  bus_a.vga_r, 4'h0);
    check("blank_a_g",  bus_a.vga_g, 4'h0);
    check("blank_a_b",  bus_a.vga_b, 4'h0);
    check("blank_a_de", bus_a.vga_de, 1'b0);
    check("blank_b_g",  bus_b.vga_g, 8'h00);
    check("hs_act_a",   bus_a.vga_hs, 1'b1);
    check("hs_act_b",   bus_b.vga_hs, 1'b0);

    // Lines y=1, y=2, then x0 y3 (t=15) saturation
    pix(1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    pix(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    pix(1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    pix(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    pix(1, 1, 0, 0, 8'hFF, 8'hFF, 8'h70);
    pix(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    pix(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    check("t15_a_r", bus_a.vga_r, 4'hF);
    check("t15_a_g", bus_a.vga_g, 4'hF);
    check("t15_a_b", bus_a.vga_b, 4'h7);
    check("t15_b_r", bus_b.vga_r, 6'h3F);
    check("t15_b_g", bus_b.vga_g, 8'hFF);
    check("t15_b_b", bus_b.vga_b, 1'b1);

    // Tick gating / latency: new pixel presented one clock after a tick
    hde = 1'b0; vde = 1'b1; {r_in, g_in, b_in} = '0;
    step();
    hde = 1'b1; {r_in, g_in, b_in} = {3{8'h10}};
    lat    = 0;
    r_rise = 4'h0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (lat == 0 && bus_a.vga_de === 1'b1) begin
        lat    = i;
        r_rise = bus_a.vga_r;
      end
    end
    check("latency_clks", lat, 12);
    check("latency_r",    r_rise, 4'h1);
    check("pc_ena_out",   bus_a.pc_ena_out, 4'd3);

    // Vertical blank: frame counter and vsync
    pix(0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    check("fc_a_1", bus_a.frame_count, 8'd1);
    check("fc_b_1", bus_b.frame_count, 8'd1);
    pix(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    pix(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    check("vs_act_a", bus_a.vga_vs, 1'b1);
    check("vs_act_b", bus_b.vga_vs, 1'b0);

    // Reset asserted mid-line
    pix(1, 1, 0, 0, 8'hFF, 8'hFF, 8'hFF);
    pix(1, 1, 0, 0, 8'hFF, 8'hFF, 8'hFF);
    pix(1, 1, 0, 0, 8'hFF, 8'hFF, 8'hFF);
    check("pre_rst_a_r", bus_a.vga_r, 4'hF);
    step();
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_a_r",   bus_a.vga_r, 4'h0);
    check("mid_rst_a_de",  bus_a.vga_de, 1'b0);
    check("mid_rst_a_fc",  bus_a.frame_count, 8'd0);
    check("mid_rst_b_hs",  bus_b.vga_hs, 1'b1);
    check("mid_rst_a_pco", bus_a.pc_ena_out, 4'd0);
    step();
    step();
    rst = 1'b0;
    pix(1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    pix(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    check("post_rst_fc", bus_a.frame_count, 8'd1);

    // Frame 1, x0 y0: column shifts by one when temporal dither is built in
    pix(1, 1, 0, 0, 8'h88, 8'h88, 8'h88);
    pix(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    pix(0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
`ifdef VGA_DITHER_TEMPORAL_EN
    check("temporal_a_r", bus_a.vga_r, 4'h9);
`else
    check("temporal_a_r", bus_a.vga_r, 4'h8);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
